// File: rtl/cv32e40p_aligner_tmr_if.sv
// Handshake and bus signals between prefetch buffer, aligner and decode.
// The aligner itself uses the slave modport; the environment driving it uses master.
interface cv32e40p_aligner_tmr_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        aligner_ready_o;
    logic        if_valid_i;
    logic        instr_valid_o;
    logic [31:0] instr_aligned_o;
    logic [31:0] pc_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        err_detected_o;
    logic        err_corrected_o;

    modport slave (
        input  fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
        output aligner_ready_o, instr_valid_o, instr_aligned_o, pc_o,
               err_detected_o, err_corrected_o
    );

    modport master (
        output fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
        input  aligner_ready_o, instr_valid_o, instr_aligned_o, pc_o,
               err_detected_o, err_corrected_o
    );
endinterface

// File: rtl/cv32e40p_aligner_tmr.sv
// Instruction aligner: turns 32-bit fetch words into one aligned (possibly compressed)
// instruction per handshake, with its PC. Define ALIGNER_TMR_EN to triplicate the
// architectural state {state, r_instr_h, pc} with bitwise majority voting and scrubbing.
// rst_n is a synchronous, active-high reset.
module cv32e40p_aligner_tmr #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input logic                   clk,
    input logic                   rst_n,
    cv32e40p_aligner_tmr_if.slave bus
);

    typedef enum logic [1:0] {
        StAligned32,
        StMisaligned32,
        StMisaligned16,
        StBranchMisaligned
    } state_e;

    typedef struct packed {
        state_e      state;
        logic [15:0] instr_h;
        logic [31:0] pc;
    } arch_t;

    localparam int unsigned ArchW = $bits(arch_t);
    localparam arch_t ResetVal = '{state: StAligned32, instr_h: 16'h0, pc: BOOT_ADDR};

    arch_t            cur;
    arch_t            arch_d;
    logic [ArchW-1:0] voted;
    logic             err_det_raw;
    logic             err_corr_raw;
    logic             instr_valid;
    logic             aligner_ready;
    logic [31:0]      instr_aligned;
    logic             hs;
    logic             unused_addr_lsb;

    // Target bit 0 is meaningless for half-word aligned code.
    assign unused_addr_lsb = bus.branch_addr_i[0];

`ifdef ALIGNER_TMR_EN
    logic [ArchW-1:0] copy0_q, copy1_q, copy2_q;
    logic [2:0]       diff;

    assign voted = (copy0_q & copy1_q) | (copy0_q & copy2_q) | (copy1_q & copy2_q);
    assign diff  = {|(copy2_q ^ voted), |(copy1_q ^ voted), |(copy0_q ^ voted)};
    assign err_det_raw  = |diff;
    assign err_corr_raw = err_det_raw && ($countones(diff) == 1);

    // All copies reload the voted next state every cycle, which scrubs single upsets.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            copy0_q <= ResetVal;
            copy1_q <= ResetVal;
            copy2_q <= ResetVal;
        end else begin
            copy0_q <= arch_d;
            copy1_q <= arch_d;
            copy2_q <= arch_d;
        end
    end
`else
    logic [ArchW-1:0] arch_q;

    assign voted        = arch_q;
    assign err_det_raw  = 1'b0;
    assign err_corr_raw = 1'b0;

    // Single-copy architectural state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            arch_q <= ResetVal;
        end else begin
            arch_q <= arch_d;
        end
    end
`endif

    assign cur = arch_t'(voted);
    assign hs  = instr_valid && bus.if_valid_i;

    // Alignment FSM: outputs and next architectural state from the voted state.
    always_comb begin
        arch_d        = cur;
        instr_valid   = 1'b0;
        aligner_ready = 1'b0;
        instr_aligned = 32'h0;
        if (bus.branch_i) begin
            arch_d.pc    = {bus.branch_addr_i[31:1], 1'b0};
            arch_d.state = bus.branch_addr_i[1] ? StBranchMisaligned : StAligned32;
        end else begin
            unique case (cur.state)
                StAligned32: begin
                    instr_valid   = bus.fetch_valid_i;
                    aligner_ready = bus.if_valid_i;
                    if (bus.fetch_rdata_i[1:0] == 2'b11) begin
                        instr_aligned = bus.fetch_rdata_i;
                        if (hs) arch_d.pc = cur.pc + 32'd4;
                    end else begin
                        instr_aligned = {16'h0, bus.fetch_rdata_i[15:0]};
                        if (hs) begin
                            arch_d.pc      = cur.pc + 32'd2;
                            arch_d.instr_h = bus.fetch_rdata_i[31:16];
                            arch_d.state   = (bus.fetch_rdata_i[17:16] == 2'b11) ?
                                             StMisaligned32 : StMisaligned16;
                        end
                    end
                end
                StMisaligned32: begin
                    instr_valid   = bus.fetch_valid_i;
                    aligner_ready = bus.if_valid_i;
                    instr_aligned = {bus.fetch_rdata_i[15:0], cur.instr_h};
                    if (hs) begin
                        arch_d.pc      = cur.pc + 32'd4;
                        arch_d.instr_h = bus.fetch_rdata_i[31:16];
                        arch_d.state   = (bus.fetch_rdata_i[17:16] == 2'b11) ?
                                         StMisaligned32 : StMisaligned16;
                    end
                end
                StMisaligned16: begin
                    // Upper compressed half already buffered; no fetch word needed.
                    instr_valid   = 1'b1;
                    instr_aligned = {16'h0, cur.instr_h};
                    if (hs) begin
                        arch_d.pc    = cur.pc + 32'd2;
                        arch_d.state = StAligned32;
                    end
                end
                StBranchMisaligned: begin
                    aligner_ready = 1'b1;
                    if (bus.fetch_rdata_i[17:16] == 2'b11) begin
                        // 32-bit target straddles words: stash upper half, wait for next word.
                        if (bus.fetch_valid_i) begin
                            arch_d.instr_h = bus.fetch_rdata_i[31:16];
                            arch_d.state   = StMisaligned32;
                        end
                    end else begin
                        instr_valid   = bus.fetch_valid_i;
                        instr_aligned = {16'h0, bus.fetch_rdata_i[31:16]};
                        if (hs) begin
                            arch_d.pc    = cur.pc + 32'd2;
                            arch_d.state = StAligned32;
                        end
                    end
                end
                default: arch_d = ResetVal;
            endcase
        end
    end

    // Status outputs are held low while reset is asserted.
    always_comb begin
        bus.instr_valid_o   = instr_valid && !rst_n;
        bus.aligner_ready_o = aligner_ready && !rst_n;
        bus.err_detected_o  = err_det_raw && !rst_n;
        bus.err_corrected_o = err_corr_raw && !rst_n;
        bus.instr_aligned_o = instr_aligned;
        bus.pc_o            = cur.pc;
    end

endmodule

// File: tb/tb_cv32e40p_aligner_tmr.sv
// Directed testbench for cv32e40p_aligner_tmr. Inputs change on the falling edge;
// outputs are sampled 1ns later, well away from the rising edge.
module tb_cv32e40p_aligner_tmr;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cv32e40p_aligner_tmr_if bus ();

    cv32e40p_aligner_tmr dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n             = 1'b1;
        bus.branch_i      = 1'b0;
        bus.fetch_valid_i = 1'b0;
        next_cycle();
        rst_n = 1'b0;
    endtask

`ifdef ALIGNER_TMR_EN
    logic [49:0] tmp0;
    logic [49:0] tmp2;
`endif

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b1;
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0400;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h0041_0113;
        bus.if_valid_i    = 1'b1;

        // Reset forces status outputs low even with branch and fetch active.
        @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.instr_valid_o), 32'h0);
        check("rst_ready", 32'(bus.aligner_ready_o), 32'h0);
        check("rst_det", 32'(bus.err_detected_o), 32'h0);
        check("rst_corr", 32'(bus.err_corrected_o), 32'h0);
        next_cycle();
        rst_n             = 1'b0;
        bus.branch_i      = 1'b0;
        bus.fetch_valid_i = 1'b0;
        #1;
        check("rst_pc", bus.pc_o, 32'h0000_0080);

        // Aligned 32-bit instruction.
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h0041_0113;
        #1;
        check("a32_valid", 32'(bus.instr_valid_o), 32'h1);
        check("a32_instr", bus.instr_aligned_o, 32'h0041_0113);
        check("a32_pc", bus.pc_o, 32'h0000_0080);
        check("a32_ready", 32'(bus.aligner_ready_o), 32'h1);
        next_cycle();
        bus.fetch_valid_i = 1'b0;
        #1;
        check("a32_pc_next", bus.pc_o, 32'h0000_0084);
        check("a32_idle_valid", 32'(bus.instr_valid_o), 32'h0);

        // Two compressed instructions in one word, with a decode stall on the second.
        do_reset();
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h4505_4501;
        #1;
        check("c16a_instr", bus.instr_aligned_o, 32'h0000_4501);
        check("c16a_pc", bus.pc_o, 32'h0000_0080);
        next_cycle();
        bus.fetch_valid_i = 1'b0;
        bus.if_valid_i    = 1'b0;
        #1;
        check("c16b_valid", 32'(bus.instr_valid_o), 32'h1);
        check("c16b_instr", bus.instr_aligned_o, 32'h0000_4505);
        check("c16b_pc", bus.pc_o, 32'h0000_0082);
        check("c16b_ready", 32'(bus.aligner_ready_o), 32'h0);
        next_cycle();
        #1;
        check("c16b_stall_pc", bus.pc_o, 32'h0000_0082);
        bus.if_valid_i = 1'b1;
        next_cycle();
        #1;
        check("c16_pc_next", bus.pc_o, 32'h0000_0084);
        check("c16_idle_valid", 32'(bus.instr_valid_o), 32'h0);

        // Compressed followed by a misaligned 32-bit instruction, no bubble.
        do_reset();
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h0113_4501;
        #1;
        check("mis_c_instr", bus.instr_aligned_o, 32'h0000_4501);
        check("mis_c_pc", bus.pc_o, 32'h0000_0080);
        next_cycle();
        bus.fetch_rdata_i = 32'hDEAD_0041;
        #1;
        check("mis32_valid", 32'(bus.instr_valid_o), 32'h1);
        check("mis32_instr", bus.instr_aligned_o, 32'h0041_0113);
        check("mis32_pc", bus.pc_o, 32'h0000_0082);
        next_cycle();
        bus.fetch_valid_i = 1'b0;
        #1;
        check("mis32_pc_next", bus.pc_o, 32'h0000_0086);
        check("mis16_instr", bus.instr_aligned_o, 32'h0000_DEAD);

        // Branch to a misaligned 32-bit target.
        do_reset();
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0203;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h0041_0113;
        #1;
        check("br_bubble_valid", 32'(bus.instr_valid_o), 32'h0);
        check("br_bubble_ready", 32'(bus.aligner_ready_o), 32'h0);
        next_cycle();
        bus.branch_i      = 1'b0;
        bus.fetch_rdata_i = 32'h0113_1234;
        #1;
        check("brm_first_valid", 32'(bus.instr_valid_o), 32'h0);
        check("brm_first_ready", 32'(bus.aligner_ready_o), 32'h1);
        check("brm_pc", bus.pc_o, 32'h0000_0202);
        next_cycle();
        bus.fetch_rdata_i = 32'hDEAD_0041;
        #1;
        check("brm_valid", 32'(bus.instr_valid_o), 32'h1);
        check("brm_instr", bus.instr_aligned_o, 32'h0041_0113);
        check("brm_instr_pc", bus.pc_o, 32'h0000_0202);
        next_cycle();
        bus.fetch_valid_i = 1'b0;
        #1;
        check("brm_pc_next", bus.pc_o, 32'h0000_0206);

        // Branch to a compressed upper half at the top of memory: PC wraps to 0.
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'hFFFF_FFFE;
        next_cycle();
        bus.branch_i      = 1'b0;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h4505_0000;
        #1;
        check("wrap_valid", 32'(bus.instr_valid_o), 32'h1);
        check("wrap_instr", bus.instr_aligned_o, 32'h0000_4505);
        check("wrap_pc", bus.pc_o, 32'hFFFF_FFFE);
        next_cycle();
        bus.fetch_valid_i = 1'b0;
        #1;
        check("wrap_pc_next", bus.pc_o, 32'h0000_0000);
        check("wrap_idle_valid", 32'(bus.instr_valid_o), 32'h0);

        // Reset in MISALIGNED32 with a branch pending: reset wins, half-word dropped.
        do_reset();
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h0113_4501;
        next_cycle();
        rst_n             = 1'b1;
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0400;
        #1;
        check("rmid_valid", 32'(bus.instr_valid_o), 32'h0);
        check("rmid_ready", 32'(bus.aligner_ready_o), 32'h0);
        check("rmid_det", 32'(bus.err_detected_o), 32'h0);
        check("rmid_corr", 32'(bus.err_corrected_o), 32'h0);
        next_cycle();
        rst_n             = 1'b0;
        bus.branch_i      = 1'b0;
        bus.fetch_rdata_i = 32'h0041_0113;
        #1;
        check("rmid_pc", bus.pc_o, 32'h0000_0080);
        check("rmid_instr", bus.instr_aligned_o, 32'h0041_0113);
        check("rmid_no_err", 32'(bus.err_detected_o), 32'h0);

`ifdef ALIGNER_TMR_EN
        // Hold the state still, then inject upsets into individual copies.
        bus.fetch_valid_i = 1'b0;
        bus.if_valid_i    = 1'b0;
        next_cycle();
        tmp0 = dut.copy1_q ^ 50'h20;
        force dut.copy1_q = tmp0;
        #1;
        check("seu_det", 32'(bus.err_detected_o), 32'h1);
        check("seu_corr", 32'(bus.err_corrected_o), 32'h1);
        check("seu_pc", bus.pc_o, 32'h0000_0080);
        release dut.copy1_q;
        next_cycle();
        #1;
        check("seu_scrub_det", 32'(bus.err_detected_o), 32'h0);
        check("seu_scrub_pc", bus.pc_o, 32'h0000_0080);
        tmp0 = dut.copy0_q ^ 50'h08;
        tmp2 = dut.copy2_q ^ 50'h80;
        force dut.copy0_q = tmp0;
        force dut.copy2_q = tmp2;
        #1;
        check("meu_det", 32'(bus.err_detected_o), 32'h1);
        check("meu_corr", 32'(bus.err_corrected_o), 32'h0);
        check("meu_pc", bus.pc_o, 32'h0000_0080);
        release dut.copy0_q;
        release dut.copy2_q;
        next_cycle();
        #1;
        check("meu_scrub_det", 32'(bus.err_detected_o), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_aligner_tmr.md
# cv32e40p_aligner_tmr

Instruction aligner that sits directly upstream of the fault-tolerant compressed decoder. It accepts 32-bit words from the prefetch buffer and produces one aligned instruction per handshake, together with its PC. It handles compressed (16-bit) and misaligned 32-bit instructions, and branch redirects. Its architectural state (FSM, stored upper half-word, PC) is optionally triplicated, majority-voted and scrubbed every cycle.

## Interface
- BOOT_ADDR, 32'h0000_0080, PC loaded at reset.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-high (1 = reset asserted).
- fetch_valid_i  input  1  fetch_rdata_i holds a valid word.
- fetch_rdata_i  input  32  fetched word.
- aligner_ready_o  output  1  the current fetch word is consumed this cycle when fetch_valid_i is also 1.
- if_valid_i  input  1  decode accepts instr_aligned_o this cycle.
- instr_valid_o  output  1  instr_aligned_o and pc_o are valid.
- instr_aligned_o  output  32  instruction for the compressed decoder; compressed instructions are output as {16'h0, c}.
- pc_o  output  32  PC of instr_aligned_o.
- branch_i  input  1  redirect request.
- branch_addr_i  input  32  redirect target; bit 0 is ignored.
- err_detected_o  output  1  the state copies disagree this cycle.
- err_corrected_o  output  1  the disagreement is confined to a single copy.

## Operation
- State: FSM (ALIGNED32, MISALIGNED32, MISALIGNED16, BRANCH_MISALIGNED), r_instr_h[15:0], pc[31:0].
- Accept: a handshake is `instr_valid_o && if_valid_i`. State advances only on a handshake, except in the BRANCH_MISALIGNED 32-bit case below.
- ALIGNED32
  - instr_valid_o = fetch_valid_i.
  - If fetch_rdata_i[1:0]==2'b11: output the word; pc += 4; stay in ALIGNED32.
  - Otherwise: output {16'h0, rdata[15:0]}; pc += 2; r_instr_h ← rdata[31:16]; go to MISALIGNED32 if rdata[17:16]==2'b11, else MISALIGNED16.
  - aligner_ready_o = if_valid_i.
- MISALIGNED32
  - instr_valid_o = fetch_valid_i.
  - Output {rdata[15:0], r_instr_h}; pc += 4; r_instr_h ← rdata[31:16]; next state chosen as in ALIGNED32 (MISALIGNED32 or MISALIGNED16).
  - aligner_ready_o = if_valid_i.
- MISALIGNED16
  - instr_valid_o = 1, independent of fetch.
  - Output {16'h0, r_instr_h}; pc += 2; go to ALIGNED32.
  - aligner_ready_o = 0.
- BRANCH_MISALIGNED
  - aligner_ready_o = 1. The lower half of the fetch word is discarded.
  - If rdata[17:16]==2'b11: instr_valid_o = 0; r_instr_h ← rdata[31:16]; go to MISALIGNED32 on fetch_valid_i alone.
  - Otherwise: instr_valid_o = fetch_valid_i; output {16'h0, rdata[31:16]}; pc += 2; go to ALIGNED32 on handshake.
- Branch
  - branch_i has priority over everything else.
  - That cycle: instr_valid_o = 0 and aligner_ready_o = 0.
  - Next cycle: pc = {branch_addr_i[31:1], 1'b0}; state = BRANCH_MISALIGNED if branch_addr_i[1], else ALIGNED32.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFE + 2 wraps to 0.
- Reset (rst_n = 1)
  - Next edge: state = ALIGNED32, pc = BOOT_ADDR, r_instr_h = 0.
  - While rst_n is asserted, instr_valid_o, aligner_ready_o, err_detected_o and err_corrected_o are forced to 0.
  - Reset overrides branch_i. Reset mid-instruction drops any stored half-word.

## Timing
- Outputs are combinational from the voted state and the fetch inputs. Zero-cycle latency from fetch_valid_i to instr_valid_o.
- A misaligned 32-bit instruction following a compressed one costs no bubble.
- A branch costs one bubble cycle. A misaligned 32-bit target costs one additional fetch cycle.
- err_detected_o and err_corrected_o are combinational from the register copies. They are valid in the same cycle the upset is visible.

## Configuration
- ALIGNER_TMR_EN defined:
  - Three copies of {state, r_instr_h, pc}.
  - The bitwise majority is the voted state. Every copy loads the same voted next state each cycle, including stall cycles, so a single upset is scrubbed within 1 cycle.
  - err_detected_o = any copy differs from the voted value.
  - err_corrected_o = err_detected_o and exactly one copy differs, across all fields.
- ALIGNER_TMR_EN undefined:
  - Single copy of the state.
  - err_detected_o = err_corrected_o = 0.

## Test plan
- Reset, then feed 32'h0041_0113 with if_valid_i = 1 → instr_aligned_o = 32'h0041_0113, pc_o = 32'h80, then pc = 32'h84, state stays ALIGNED32.
- Feed 32'h4505_4501 (two compressed) → outputs 32'h0000_4501 at pc 32'h80, then 32'h0000_4505 at pc 32'h82 with aligner_ready_o = 0 and no fetch needed, then pc = 32'h84.
- Feed 32'h0113_4501, then 32'hxxxx_0041 → 32'h0000_4501 at pc 32'h80, then 32'h0041_0113 at pc 32'h82, then pc = 32'h86.
- branch_i = 1, branch_addr_i = 32'h202; feed 32'h0113_xxxx, then 32'hxxxx_0041 → one bubble, no output on the first word, then 32'h0041_0113 at pc 32'h202.
- TMR build: force copy 1 pc[5] flipped for 1 cycle → err_detected_o = 1 and err_corrected_o = 1 for that cycle; pc_o unaffected; copies equal next cycle. Flip copy 0 bit 3 and copy 2 bit 7 together → err_detected_o = 1, err_corrected_o = 0.
- Assert rst_n while in MISALIGNED32 with branch_i = 1 → next cycle state = ALIGNED32, pc = 32'h80, all outputs 0 during reset.
